register_file: RTL and testbench

- 8-entry x 8-bit general-purpose register file for the single-cycle datapath.
- Two combinational read ports. Read port B drives the in0 operand of the ALU-operand mux2; the immediate drives in1.
- One synchronous write port, fed from the writeback value.
- r0 is hardwired to zero. Optional write-to-read bypass.

---
 rtl/datapath_pkg.sv | 14 +
 rtl/register8.sv | 22 ++
 rtl/register_file.sv | 76 +++++++
 tb/tb_register_file.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types and constants used by the register file, ALU,
// operand mux and instruction decoder.
package datapath_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int REG_DEPTH      = 2 ** REG_ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 3'd0;

endpackage : datapath_pkg

// File: rtl/register8.sv
// Single datapath register with load enable and asynchronous active-low clear.
module register8 #(
    parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs before any of them change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : register8

// File: rtl/register_file.sv
// 8x8 register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero r0 and optional write-to-read bypass.
module register_file
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = datapath_pkg::REG_ADDR_WIDTH,
    parameter int ZERO_R0    = 1,
    parameter int BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  write_ok;
    logic                  bypass_a;
    logic                  bypass_b;

    // A write to r0 is dropped when r0 is hardwired, so it never bypasses either.
    assign write_ok = write_enable &&
                      !((ZERO_R0 != 0) && (write_addr == ADDR_WIDTH'(REG_ZERO)));

    // NOTE: storage is built from individually resettable registers rather than
    // an inferred RAM, because reset must clear every entry at once.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
            assign regs_q[i] = '0;
        end else begin : g_store
            logic load;

            assign load = write_enable && (write_addr == ADDR_WIDTH'(i));

            register8 #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_reg (
                .clk    (clk),
                .reset_n(reset_n),
                .load   (load),
                .d      (write_data),
                .q      (regs_q[i])
            );
        end
    end

    assign bypass_a = (BYPASS != 0) && write_ok && (write_addr == read_addr_a);
    assign bypass_b = (BYPASS != 0) && write_ok && (write_addr == read_addr_b);

    // NOTE: every output gets a default before the conditional overrides so the
    // combinational block cannot infer a latch.
    always_comb begin
        read_data_a = regs_q[read_addr_a];
        read_data_b = regs_q[read_addr_b];
        if (bypass_a) begin
            read_data_a = write_data;
        end
        if (bypass_b) begin
            read_data_b = write_data;
        end
        // Outputs stay zero for the whole reset window, bypass included.
        if (!reset_n) begin
            read_data_a = '0;
            read_data_b = '0;
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file, exercising BYPASS=0 and BYPASS=1 builds side by side.
module tb_register_file;

    logic       clk;
    logic       reset_n;
    logic [2:0] read_addr_a;
    logic [2:0] read_addr_b;
    logic       write_enable;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       mux_sel;
    logic [7:0] mux_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    register_file #(.ZERO_R0(1), .BYPASS(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda0), .read_data_b(rdb0),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
    );

    register_file #(.ZERO_R0(1), .BYPASS(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda1), .read_data_b(rdb1),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
    );

    // Downstream operand mux2: in0 = read port B, in1 = immediate.
    assign mux_out = mux_sel ? 8'h0F : rdb0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input string name, input logic [7:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb);
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr_a  = ra;
        read_addr_b  = rb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 3'd1, 8'hAA, 3'd1, 3'd0, 8'hAA, 8'h00};
        vecs[1] = '{1'b1, 3'd2, 8'h55, 3'd1, 3'd2, 8'hAA, 8'h55};
        vecs[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd1, 8'h00, 8'hAA};
        vecs[3] = '{1'b1, 3'd3, 8'h12, 3'd3, 3'd3, 8'h12, 8'h12};
        vecs[4] = '{1'b0, 3'd3, 8'h34, 3'd3, 3'd2, 8'h12, 8'h55};
        vecs[5] = '{1'b0, 3'd3, 8'h34, 3'd3, 3'd2, 8'h12, 8'h55};
        vecs[6] = '{1'b0, 3'd3, 8'h34, 3'd3, 3'd2, 8'h12, 8'h55};
        vecs[7] = '{1'b1, 3'd4, 8'h10, 3'd4, 3'd3, 8'h10, 8'h12};
        vecs[8] = '{1'b1, 3'd6, 8'hC3, 3'd6, 3'd6, 8'hC3, 8'hC3};

        // Reset held 20 ns with a write attempted throughout.
        mux_sel = 1'b0;
        reset_n = 1'b0;
        drive(1'b1, 3'd1, 8'hAA, 3'd1, 3'd1);
        #8;
        check("in_reset_a0", rda0, 8'h00);
        check("in_reset_b1", rdb1, 8'h00);
        #12;
        reset_n = 1'b1;
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_addr_a = 3'(i);
            read_addr_b = 3'(7 - i);
            #1;
            check($sformatf("reset_a0_r%0d", i), rda0, 8'h00);
            check($sformatf("reset_b0_r%0d", 7 - i), rdb0, 8'h00);
            check($sformatf("reset_a1_r%0d", i), rda1, 8'h00);
            check($sformatf("reset_b1_r%0d", 7 - i), rdb1, 8'h00);
        end

        // Table: write at the edge, read back just after it.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ra, vecs[v].rb);
            expect_val(vecs[v].exp_a);
            expect_val(vecs[v].exp_b);
            expect_val(vecs[v].exp_a);
            expect_val(vecs[v].exp_b);
            @(posedge clk);
            #1;
            check_next($sformatf("vec%0d_a0", v), rda0);
            check_next($sformatf("vec%0d_b0", v), rdb0);
            check_next($sformatf("vec%0d_a1", v), rda1);
            check_next($sformatf("vec%0d_b1", v), rdb1);
        end

        // Operand mux2 alternation with read port B on r2.
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
        for (int i = 0; i < 4; i++) begin
            mux_sel = i[0];
            expect_val(i[0] ? 8'h0F : 8'h55);
            #1;
            check_next($sformatf("mux_sel%0d", i), mux_out);
        end

        // Same-cycle read/write of r4 (currently 8'h10).
        @(negedge clk);
        drive(1'b1, 3'd4, 8'h20, 3'd0, 3'd4);
        #1;
        check("rw_before_b0", rdb0, 8'h10);
        check("rw_before_b1", rdb1, 8'h20);
        @(posedge clk);
        #1;
        check("rw_after_b0", rdb0, 8'h20);
        check("rw_after_b1", rdb1, 8'h20);

        // Bypass must not expose a dropped write to r0.
        @(negedge clk);
        drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
        #1;
        check("r0_bypass_a1", rda1, 8'h00);
        @(posedge clk);
        #1;
        check("r0_after_a0", rda0, 8'h00);

        // Load r5 and r7, then pulse reset between edges.
        @(negedge clk);
        drive(1'b1, 3'd5, 8'h77, 3'd5, 3'd7);
        @(negedge clk);
        drive(1'b1, 3'd7, 8'h99, 3'd5, 3'd7);
        @(negedge clk);
        write_enable = 1'b0;
        #1;
        check("pre_rst_a0", rda0, 8'h77);
        check("pre_rst_b0", rdb0, 8'h99);
        reset_n = 1'b0;
        drive(1'b1, 3'd5, 8'hEE, 3'd5, 3'd7);
        #1;
        check("async_rst_a0", rda0, 8'h00);
        check("async_rst_b0", rdb0, 8'h00);
        check("async_rst_a1", rda1, 8'h00);
        check("async_rst_b1", rdb1, 8'h00);
        #2;
        reset_n = 1'b1;
        write_enable = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_r5", rda0, 8'h00);
        check("post_rst_r7", rdb0, 8'h00);
        read_addr_a = 3'd1;
        #1;
        check("post_rst_r1", rda0, 8'h00);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_file
